// File: rtl/cache_ctrl_pkg.sv
// Shared types and constants for the burst cache controller.
//   state_t    : controller FSM states
//   word_bits  : WordSel width for a given line size, never below 1
//   POLICY_*   : encodings for the WRITE_BACK parameter
//   TIMER_W    : width of the per-beat wait-state counter
package cache_ctrl_pkg;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOOKUP = 3'd1,
    S_EVICT  = 3'd2,
    S_REFILL = 3'd3,
    S_WMEM   = 3'd4,
    S_DONE   = 3'd5
  } state_t;

  localparam int unsigned POLICY_WT = 0;
  localparam int unsigned POLICY_WB = 1;
  localparam int unsigned TIMER_W   = 8;

  function automatic int unsigned word_bits(input int unsigned line_words);
    return (line_words <= 2) ? 1 : $clog2(line_words);
  endfunction

endpackage

// File: rtl/cache_ctrl_burst_beat_timer.sv
// Loadable down-counter that times one memory beat.
//   clk, reset   : clock, asynchronous active-low reset
//   load         : load load_val on the next edge
//   load_val     : wait-state count for the beat
//   done         : count has reached zero (final cycle of the beat)
module beat_timer
  import cache_ctrl_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic               load,
  input  logic [TIMER_W-1:0] load_val,
  output logic               done
);

  logic [TIMER_W-1:0] count_q, count_d;

  // Load wins; otherwise count down and park at zero.
  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = load_val;
    end else if (count_q != '0) begin
      count_d = count_q - TIMER_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign done = (count_q == '0);

endmodule

// File: rtl/cache_ctrl_burst.sv
// Direct-mapped cache controller with multi-word line refill, programmable
// memory wait states and selectable write-through / write-back policy.
//   CPU side   : Strobe, DRW in; DReady out
//   Tag lookup : M, V, D in (valid during LOOKUP)
//   Array      : W, WTag, SetDirty, ClrDirty, WSel, WordSel out
//   Memory     : MStrobe, MRW, RSel out
//   Status     : Busy out (state != IDLE)
// Outputs are decoded from registered state; only LOOKUP looks at M/V/D.
module cache_ctrl_burst
  import cache_ctrl_pkg::*;
#(
  parameter int unsigned WAIT_CYCLES = 4,
  parameter int unsigned LINE_WORDS  = 4,
  parameter int unsigned WRITE_BACK  = 0
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic                                Strobe,
  input  logic                                DRW,
  input  logic                                M,
  input  logic                                V,
  input  logic                                D,
  output logic                                DReady,
  output logic                                W,
  output logic                                WTag,
  output logic                                SetDirty,
  output logic                                ClrDirty,
  output logic                                MStrobe,
  output logic                                MRW,
  output logic                                RSel,
  output logic                                WSel,
  output logic [word_bits(LINE_WORDS)-1:0]    WordSel,
  output logic                                Busy
);

  localparam int unsigned        BEAT_W    = word_bits(LINE_WORDS);
  localparam logic [BEAT_W-1:0]  LAST_BEAT = BEAT_W'(LINE_WORDS - 1);
  localparam logic [TIMER_W-1:0] WAIT_VAL  = TIMER_W'(WAIT_CYCLES);
  localparam bit                 IS_WB     = (WRITE_BACK == POLICY_WB);

  state_t            state_q, state_d;
  logic [BEAT_W-1:0] beat_q, beat_d;
  logic              drw_q, drw_d;
  logic              start_q, start_d;
  logic              load_c;
  logic              beat_done;
  logic              hit;
  logic              last_beat;

  assign hit       = M & V;
  assign last_beat = (beat_q == LAST_BEAT);

  // Timer is loaded on the edge that enters a beat, so it already holds
  // WAIT_CYCLES in the beat's first cycle and reads zero in its last.
  beat_timer u_beat_timer (
    .clk      (clk),
    .reset    (reset),
    .load     (load_c),
    .load_val (WAIT_VAL),
    .done     (beat_done)
  );

  // Next-state, counter and output decode.
  always_comb begin
    state_d  = state_q;
    beat_d   = beat_q;
    drw_d    = drw_q;
    load_c   = 1'b0;
    DReady   = 1'b0;
    W        = 1'b0;
    WTag     = 1'b0;
    SetDirty = 1'b0;
    ClrDirty = 1'b0;
    MStrobe  = 1'b0;
    MRW      = 1'b0;
    RSel     = 1'b0;
    WSel     = 1'b0;
    WordSel  = '0;
    Busy     = (state_q != S_IDLE);

    case (state_q)
      S_IDLE: begin
        if (Strobe) begin
          drw_d   = DRW;
          state_d = S_LOOKUP;
        end
      end

      S_LOOKUP: begin
        if (!drw_q) begin
          DReady = hit;
          if (hit) begin
            state_d = S_IDLE;
          end else begin
            load_c  = 1'b1;
            beat_d  = '0;
            state_d = (IS_WB && V && D) ? S_EVICT : S_REFILL;
          end
        end else if (!IS_WB) begin
          // Write-through: update the array on a hit, always post to memory.
          W       = hit;
          load_c  = 1'b1;
          state_d = S_WMEM;
        end else if (hit) begin
          W        = 1'b1;
          SetDirty = 1'b1;
          DReady   = 1'b1;
          state_d  = S_IDLE;
        end else begin
          load_c  = 1'b1;
          beat_d  = '0;
          state_d = (V && D) ? S_EVICT : S_REFILL;
        end
      end

      S_EVICT: begin
        MStrobe = start_q;
        MRW     = 1'b1;
        RSel    = 1'b1;
        WordSel = beat_q;
        if (beat_done) begin
          load_c = 1'b1;
          if (last_beat) begin
            beat_d  = '0;
            state_d = S_REFILL;
          end else begin
            beat_d = beat_q + BEAT_W'(1);
          end
        end
      end

      S_REFILL: begin
        MStrobe = start_q;
        WordSel = beat_q;
        if (beat_done) begin
          W    = 1'b1;
          WSel = 1'b1;
          if (last_beat) begin
            WTag     = 1'b1;
            ClrDirty = 1'b1;
            beat_d   = '0;
            state_d  = S_DONE;
          end else begin
            load_c = 1'b1;
            beat_d = beat_q + BEAT_W'(1);
          end
        end
      end

      S_WMEM: begin
        MStrobe = start_q;
        MRW     = 1'b1;
        if (beat_done) begin
          state_d = S_DONE;
        end
      end

      S_DONE: begin
        DReady = 1'b1;
        // Write-back writes reach DONE only on a miss: merge CPU data now.
        if (IS_WB && drw_q) begin
          W        = 1'b1;
          SetDirty = 1'b1;
        end
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    start_d = load_c;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      beat_q  <= '0;
      drw_q   <= 1'b0;
      start_q <= 1'b0;
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
      drw_q   <= drw_d;
      start_q <= start_d;
    end
  end

endmodule

// File: tb/tb_cache_ctrl_burst.sv
// Directed bench for cache_ctrl_burst in three configurations:
//   u_dut0 : defaults (WAIT_CYCLES=4, LINE_WORDS=4, write-through)
//   u_dut1 : write-back, otherwise defaults
//   u_dut2 : WAIT_CYCLES=0, LINE_WORDS=1, write-through
// Inputs are driven on the falling edge; "rel" counts falling edges after the
// one on which Strobe was raised (rel=1 is the LOOKUP cycle).
module tb_cache_ctrl_burst;

  logic clk;
  logic reset;
  logic DRW, M, V, D;
  logic strobe0, strobe1, strobe2;

  logic dready0, w0, wtag0, setd0, clrd0, mstb0, mrw0, rsel0, wsel0, busy0;
  logic dready1, w1, wtag1, setd1, clrd1, mstb1, mrw1, rsel1, wsel1, busy1;
  logic dready2, w2, wtag2, setd2, clrd2, mstb2, mrw2, rsel2, wsel2, busy2;
  logic [1:0] wsi0, wsi1;
  logic [0:0] wsi2;

  // Bit order: DReady W WTag SetDirty ClrDirty MStrobe MRW RSel WSel Busy
  logic [9:0] out0, out1, out2;
  assign out0 = {dready0, w0, wtag0, setd0, clrd0, mstb0, mrw0, rsel0, wsel0, busy0};
  assign out1 = {dready1, w1, wtag1, setd1, clrd1, mstb1, mrw1, rsel1, wsel1, busy1};
  assign out2 = {dready2, w2, wtag2, setd2, clrd2, mstb2, mrw2, rsel2, wsel2, busy2};

  int n_checks;
  int n_fail;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  cache_ctrl_burst #(.WAIT_CYCLES(4), .LINE_WORDS(4), .WRITE_BACK(0)) u_dut0 (
    .clk(clk), .reset(reset), .Strobe(strobe0), .DRW(DRW), .M(M), .V(V), .D(D),
    .DReady(dready0), .W(w0), .WTag(wtag0), .SetDirty(setd0), .ClrDirty(clrd0),
    .MStrobe(mstb0), .MRW(mrw0), .RSel(rsel0), .WSel(wsel0), .WordSel(wsi0),
    .Busy(busy0)
  );

  cache_ctrl_burst #(.WAIT_CYCLES(4), .LINE_WORDS(4), .WRITE_BACK(1)) u_dut1 (
    .clk(clk), .reset(reset), .Strobe(strobe1), .DRW(DRW), .M(M), .V(V), .D(D),
    .DReady(dready1), .W(w1), .WTag(wtag1), .SetDirty(setd1), .ClrDirty(clrd1),
    .MStrobe(mstb1), .MRW(mrw1), .RSel(rsel1), .WSel(wsel1), .WordSel(wsi1),
    .Busy(busy1)
  );

  cache_ctrl_burst #(.WAIT_CYCLES(0), .LINE_WORDS(1), .WRITE_BACK(0)) u_dut2 (
    .clk(clk), .reset(reset), .Strobe(strobe2), .DRW(DRW), .M(M), .V(V), .D(D),
    .DReady(dready2), .W(w2), .WTag(wtag2), .SetDirty(setd2), .ClrDirty(clrd2),
    .MStrobe(mstb2), .MRW(mrw2), .RSel(rsel2), .WSel(wsel2), .WordSel(wsi2),
    .Busy(busy2)
  );

  // Raise Strobe on one DUT with the given request and tag inputs.
  task automatic issue(input int which, input logic drw, input logic m,
                       input logic v, input logic d);
    @(negedge clk);
    DRW = drw; M = m; V = v; D = d;
    strobe0 = (which == 0);
    strobe1 = (which == 1);
    strobe2 = (which == 2);
  endtask

  task automatic idle_gap();
    strobe0 = 1'b0; strobe1 = 1'b0; strobe2 = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset();
    reset = 1'b0;
    strobe0 = 1'b0; strobe1 = 1'b0; strobe2 = 1'b0;
    DRW = 1'b0; M = 1'b0; V = 1'b0; D = 1'b0;
    repeat (2) @(negedge clk);
    n_checks++;
    if (out0 !== 10'd0 || wsi0 !== 2'd0) begin
      n_fail++;
      $display("FAIL reset_dut0 outs=%b ws=%0d expected all zero", out0, wsi0);
    end
    n_checks++;
    if (out1 !== 10'd0 || wsi1 !== 2'd0) begin
      n_fail++;
      $display("FAIL reset_dut1 outs=%b ws=%0d expected all zero", out1, wsi1);
    end
    n_checks++;
    if (out2 !== 10'd0 || wsi2 !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_dut2 outs=%b ws=%0d expected all zero", out2, wsi2);
    end
    reset = 1'b1;
    repeat (2) @(negedge clk);
    n_checks++;
    if (out0 !== 10'd0) begin
      n_fail++;
      $display("FAIL idle_after_reset outs=%b expected %b", out0, 10'd0);
    end
  endtask

  task automatic test_read_hit(input string tag);
    logic [9:0] exp;
    issue(0, 1'b0, 1'b1, 1'b1, 1'b0);
    n_checks++;
    if (out0 !== 10'd0) begin
      n_fail++;
      $display("FAIL %s_rel0 outs=%b expected %b", tag, out0, 10'd0);
    end
    for (int rel = 1; rel <= 3; rel++) begin
      @(negedge clk);
      strobe0 = 1'b0;
      exp = {(rel == 1), 8'b0, (rel == 1)};
      n_checks++;
      if (out0 !== exp) begin
        n_fail++;
        $display("FAIL %s rel=%0d outs=%b expected %b", tag, rel, out0, exp);
      end
    end
    idle_gap();
  endtask

  task automatic test_read_miss();
    logic [9:0] exp;
    logic e_mstb, e_end, e_last;
    issue(0, 1'b0, 1'b1, 1'b0, 1'b0);
    for (int rel = 1; rel <= 23; rel++) begin
      @(negedge clk);
      strobe0 = 1'b0;
      e_mstb = (rel >= 2) && (rel <= 17) && ((rel % 5) == 2);
      e_end  = (rel >= 6) && (rel <= 21) && ((rel % 5) == 1);
      e_last = (rel == 21);
      exp = {(rel == 22), e_end, e_last, 1'b0, e_last, e_mstb, 1'b0, 1'b0,
             e_end, (rel >= 1) && (rel <= 22)};
      n_checks++;
      if (out0 !== exp) begin
        n_fail++;
        $display("FAIL read_miss rel=%0d outs=%b expected %b", rel, out0, exp);
      end
      if (e_end) begin
        n_checks++;
        if (wsi0 !== 2'((rel - 6) / 5)) begin
          n_fail++;
          $display("FAIL read_miss_wordsel rel=%0d got=%0d expected=%0d",
                   rel, wsi0, (rel - 6) / 5);
        end
      end
    end
    idle_gap();
  endtask

  task automatic test_wt_write(input logic m);
    logic [9:0] exp;
    issue(0, 1'b1, m, 1'b1, 1'b0);
    for (int rel = 1; rel <= 8; rel++) begin
      @(negedge clk);
      strobe0 = 1'b0;
      exp = {(rel == 7), (rel == 1) && m, 3'b0, (rel == 2),
             (rel >= 2) && (rel <= 6), 1'b0, 1'b0, (rel >= 1) && (rel <= 7)};
      n_checks++;
      if (out0 !== exp) begin
        n_fail++;
        $display("FAIL wt_write m=%0b rel=%0d outs=%b expected %b", m, rel, out0, exp);
      end
      if (rel == 2) begin
        n_checks++;
        if (wsi0 !== 2'd0) begin
          n_fail++;
          $display("FAIL wt_write_wordsel got=%0d expected=0", wsi0);
        end
      end
    end
    idle_gap();
  endtask

  task automatic test_wb_dirty_miss();
    logic [9:0] exp;
    logic ev, rf, e_mstb, e_end, e_last, e_done;
    issue(1, 1'b1, 1'b0, 1'b1, 1'b1);
    for (int rel = 1; rel <= 44; rel++) begin
      @(negedge clk);
      strobe1 = 1'b0;
      ev     = (rel >= 2) && (rel <= 21);
      rf     = (rel >= 22) && (rel <= 41);
      e_mstb = (ev || rf) && ((rel % 5) == 2);
      e_end  = rf && ((rel % 5) == 1);
      e_last = (rel == 41);
      e_done = (rel == 42);
      exp = {e_done, e_end || e_done, e_last, e_done, e_last, e_mstb, ev, ev,
             e_end, (rel >= 1) && (rel <= 42)};
      n_checks++;
      if (out1 !== exp) begin
        n_fail++;
        $display("FAIL wb_dirty_miss rel=%0d outs=%b expected %b", rel, out1, exp);
      end
      if (ev || e_end) begin
        n_checks++;
        if (wsi1 !== 2'(((rel - 2) / 5) % 4)) begin
          n_fail++;
          $display("FAIL wb_wordsel rel=%0d got=%0d expected=%0d",
                   rel, wsi1, ((rel - 2) / 5) % 4);
        end
      end
    end
    idle_gap();
  endtask

  task automatic test_wb_write_hit();
    logic [9:0] exp;
    issue(1, 1'b1, 1'b1, 1'b1, 1'b0);
    for (int rel = 1; rel <= 2; rel++) begin
      @(negedge clk);
      strobe1 = 1'b0;
      exp = (rel == 1) ? 10'b1101000001 : 10'b0000000000;
      n_checks++;
      if (out1 !== exp) begin
        n_fail++;
        $display("FAIL wb_write_hit rel=%0d outs=%b expected %b", rel, out1, exp);
      end
    end
    idle_gap();
  endtask

  task automatic test_reset_midflight();
    issue(0, 1'b0, 1'b1, 1'b0, 1'b0);
    for (int rel = 1; rel <= 9; rel++) begin
      @(negedge clk);
      strobe0 = 1'b0;
    end
    n_checks++;
    if (busy0 !== 1'b1) begin
      n_fail++;
      $display("FAIL midflight_busy got=%b expected=1", busy0);
    end
    #1 reset = 1'b0;
    #1;
    n_checks++;
    if (out0 !== 10'd0 || wsi0 !== 2'd0) begin
      n_fail++;
      $display("FAIL midflight_reset outs=%b ws=%0d expected all zero", out0, wsi0);
    end
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    test_read_hit("post_reset_hit");
  endtask

  task automatic test_fast_miss();
    logic [9:0] exp;
    issue(2, 1'b0, 1'b1, 1'b0, 1'b0);
    for (int rel = 1; rel <= 4; rel++) begin
      @(negedge clk);
      strobe2 = 1'b0;
      exp = {(rel == 3), (rel == 2), (rel == 2), 1'b0, (rel == 2), (rel == 2),
             1'b0, 1'b0, (rel == 2), (rel >= 1) && (rel <= 3)};
      n_checks++;
      if (out2 !== exp || wsi2 !== 1'b0) begin
        n_fail++;
        $display("FAIL fast_miss rel=%0d outs=%b ws=%0d expected %b ws=0",
                 rel, out2, wsi2, exp);
      end
    end
    idle_gap();
  endtask

  // Strobe stays high; a new request is taken only when IDLE is re-entered.
  task automatic test_back_to_back();
    logic [9:0] exp;
    issue(2, 1'b0, 1'b1, 1'b0, 1'b0);
    for (int rel = 1; rel <= 8; rel++) begin
      @(negedge clk);
      exp = {((rel % 4) == 3), ((rel % 4) == 2), ((rel % 4) == 2), 1'b0,
             ((rel % 4) == 2), ((rel % 4) == 2), 1'b0, 1'b0, ((rel % 4) == 2),
             ((rel % 4) != 0)};
      n_checks++;
      if (out2 !== exp) begin
        n_fail++;
        $display("FAIL back_to_back rel=%0d outs=%b expected %b", rel, out2, exp);
      end
    end
    idle_gap();
    n_checks++;
    if (busy2 !== 1'b0) begin
      n_fail++;
      $display("FAIL back_to_back_idle busy=%b expected=0", busy2);
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    test_reset();
    test_read_hit("read_hit");
    test_read_miss();
    test_wt_write(1'b1);
    test_wt_write(1'b0);
    test_wb_dirty_miss();
    test_wb_write_hit();
    test_reset_midflight();
    test_fast_miss();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
